// File: rtl/ucsbece154_sdram_responder_if.sv
// Block-fill bus between an instruction cache (master) and the SDRAM responder (slave),
// including the preload write port used by benches to initialise the backing store.
interface ucsbece154_sdram_responder_if;
    logic        ReadRequest;
    logic [31:0] ReadAddress;
    logic [31:0] DataOut;
    logic        DataReady;
    logic        Busy;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;

    modport master (
        output ReadRequest, ReadAddress, WriteEnable, WriteAddress, WriteData,
        input  DataOut, DataReady, Busy
    );

    modport slave (
        input  ReadRequest, ReadAddress, WriteEnable, WriteAddress, WriteData,
        output DataOut, DataReady, Busy
    );
endinterface

// File: rtl/ucsbece154_sdram_responder.sv
// Behavioural SDRAM responder: returns one aligned BLOCK_WORDS burst per request, with a
// programmable first-word latency and inter-word gap, from a preloadable word array.
module ucsbece154_sdram_responder #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned T0_DELAY    = 4,
    parameter int unsigned T1_DELAY    = 1
) (
    input logic                         Clk,
    input logic                         Reset,
    ucsbece154_sdram_responder_if.slave bus
);
    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned KW   = $clog2(BLOCK_WORDS);
    localparam logic [31:0] T0Load = 32'(T0_DELAY - 1);
    localparam logic [31:0] T1Load = (T1_DELAY > 0) ? 32'(T1_DELAY - 1) : 32'd0;

    typedef enum logic [2:0] {StIdle, StWait, StBurst, StGap, StHold} state_e;

    state_e          state_q;
    logic [31:0]     cnt_q;
    logic [IdxW-1:0] ptr_q;
    logic [KW-1:0]   word_q;
    logic [31:0]     data_out_q;
    logic            data_ready_q;
    logic            busy_q;
    logic [31:0]     mem [MEM_WORDS];
    logic [IdxW-1:0] req_base;
    logic            unused_addr;

    // Word index of the block base; upper address bits simply wrap the store.
    assign req_base    = bus.ReadAddress[IdxW+1:2] & ~IdxW'(BLOCK_WORDS - 1);
    assign unused_addr = ^{bus.ReadAddress, bus.WriteAddress};

    assign bus.DataOut   = data_out_q;
    assign bus.DataReady = data_ready_q;
    assign bus.Busy      = busy_q;

    always_ff @(posedge Clk) begin
        if (bus.WriteEnable) begin
            mem[bus.WriteAddress[IdxW+1:2]] <= bus.WriteData;
        end
    end

    // Reads of mem here see the pre-edge contents, so a same-edge write returns old data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ptr_q        <= '0;
            word_q       <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.ReadRequest) begin
                        state_q <= StWait;
                        cnt_q   <= T0Load;
                        ptr_q   <= req_base;
                        busy_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (!bus.ReadRequest) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 32'd0) begin
                        data_out_q   <= mem[ptr_q];
                        data_ready_q <= 1'b1;
                        ptr_q        <= ptr_q + IdxW'(1);
                        word_q       <= '0;
                        state_q      <= StBurst;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                StBurst: begin
                    if (!bus.ReadRequest) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (word_q == KW'(BLOCK_WORDS - 1)) begin
                        state_q <= StHold;
                        busy_q  <= 1'b0;
                    end else if (T1_DELAY == 0) begin
                        data_out_q   <= mem[ptr_q];
                        data_ready_q <= 1'b1;
                        ptr_q        <= ptr_q + IdxW'(1);
                        word_q       <= word_q + KW'(1);
                    end else begin
                        state_q <= StGap;
                        cnt_q   <= T1Load;
                    end
                end
                StGap: begin
                    if (!bus.ReadRequest) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 32'd0) begin
                        data_out_q   <= mem[ptr_q];
                        data_ready_q <= 1'b1;
                        ptr_q        <= ptr_q + IdxW'(1);
                        word_q       <= word_q + KW'(1);
                        state_q      <= StBurst;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                // Holding off until the request drops keeps a lingering request from re-firing.
                StHold: begin
                    if (!bus.ReadRequest) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ucsbece154_sdram_responder.md
Name: ucsbece154_sdram_responder

Overview:
- Memory-side responder for the instruction-cache block-fill protocol: a behavioural SDRAM controller model with programmable latency.
- Accepts a level-held ReadRequest with a byte address and returns one aligned block of BLOCK_WORDS 32-bit words.
- Each word arrives with a one-cycle DataReady strobe, after a first-word latency and a fixed inter-word gap.
- Backing store is an internal word array, preloadable through a synchronous write port. Used as the fetch-side memory in core and cache benches.

Parameters:
- BLOCK_WORDS, 4, words per burst; power of 2, >=2.
- MEM_WORDS, 1024, backing-store depth in 32-bit words; power of 2.
- T0_DELAY, 4, cycles from the request-sampling edge to the first DataReady; >=1.
- T1_DELAY, 1, idle cycles between consecutive DataReady strobes; >=0 (0 = back-to-back).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high.
- ReadRequest  input  1  requester holds high until the last word is received.
- ReadAddress  input  32  byte address, sampled with the request.
- DataOut  output  32  burst word; valid only while DataReady=1.
- DataReady  output  1  one-cycle strobe per delivered word.
- Busy  output  1  high while a burst is in progress.
- WriteEnable  input  1  preload write strobe.
- WriteAddress  input  32  byte address of the preload word; bits [1:0] ignored.
- WriteData  input  32  preload data.

Behaviour:
- Reset (Reset, synchronous, active-high; clock Clk): state IDLE; DataOut=0, DataReady=0, Busy=0; counters cleared. Memory contents are NOT cleared. Reset mid-burst aborts the burst, and outputs read reset values from the following cycle.
- Address mapping:
  - Block base = ReadAddress with the low log2(BLOCK_WORDS)+2 bits cleared.
  - Word index = (base>>2)+k, taken modulo MEM_WORDS, so addresses wrap and are never out of range.
  - The sampled address is latched; later ReadAddress changes are ignored until IDLE.
- States:
  - IDLE: ReadRequest=1 at edge E0 -> WAIT. Load delay counter; Busy<=1.
  - WAIT: decrement the counter. At edge E0+T0_DELAY: DataOut<=mem[index of word 0], DataReady<=1, go to BURST.
  - BURST (the DataReady cycle):
    - If the word just shown is word BLOCK_WORDS-1 -> HOLD, with DataReady<=0 and Busy<=0.
    - Else if T1_DELAY=0, present the next word at the next edge.
    - Else go to GAP with DataReady<=0.
  - GAP: wait T1_DELAY cycles, then present the next word -> BURST.
  - HOLD: stay until ReadRequest=0, then -> IDLE. This blocks a second burst from a request still held high.
- Word k timing: DataReady rises at edge E0+T0_DELAY+k*(T1_DELAY+1), k=0..BLOCK_WORDS-1. Order is ascending from the block base (no critical-word-first).
- Busy timing: high from edge E0 until the edge after the last word's DataReady cycle.
- DataOut holds its last value when DataReady=0.
- Abort: ReadRequest=0 sampled in WAIT, BURST or GAP -> IDLE at that edge, with DataReady<=0 and Busy<=0. No further strobes.
- Preload writes:
  - WriteEnable is honoured in every state; mem[word index of WriteAddress] <= WriteData at the edge.
  - A write and a word read of the same index at the same edge: DataOut gets the OLD data (read-before-write).
- DataReady never rises outside a burst, and each burst delivers exactly BLOCK_WORDS strobes unless aborted or reset.

Test Plan:
- Preload mem[0x40..0x43]=0xA0..0xA3; request addr 0x0000010C at E0, held high until the 4th strobe -> DataReady at E0+4, +6, +8, +10. DataOut 0xA0,0xA1,0xA2,0xA3; Busy low from E0+11; state IDLE one cycle after request drops.
- T1_DELAY=0, same burst -> strobes on 4 consecutive cycles, E0+4..E0+7.
- Request held high 5 cycles past the last word -> no second burst; DataReady stays 0; new burst starts only after a 0->1 request.
- Request dropped at E0+7 (after 2 strobes) -> no strobes after E0+6; Busy=0 at E0+8. A new request to 0x200 at E0+9 -> first strobe at E0+13 with mem[0x80].
- Request at 0x0000FFF0 with MEM_WORDS=1024 -> words from indices 0x3FC..0x3FF (wrap-around mapping).
- WriteEnable to word 0x41 with 0xDEAD at the edge word 1 is presented -> DataOut=0xA1. A re-read burst returns 0xDEAD. Reset asserted mid-GAP -> DataReady/Busy/DataOut=0 the next cycle, and memory still holds 0xDEAD.
